// File: rtl/game_timer_bcd.sv
// BCD mm:ss countdown timer with IDLE/RUN/PAUSE/DONE control and a registered digit bank.
// Optional DONE-state display blink is enabled by defining GAME_TIMER_BLINK_EN.
module game_timer_bcd #(
  parameter int         CLK_HZ   = 100000000,
  parameter int         TICK_HZ  = 1,
  parameter logic [7:0] START_MM = 8'h01,
  parameter logic [7:0] START_SS = 8'h30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       blank
);

  localparam int              DIV   = CLK_HZ / TICK_HZ;
  localparam int              PW    = $clog2(DIV);
  localparam logic [PW-1:0]   LAST  = PW'(DIV - 1);
  localparam logic [15:0]     START = {START_MM, START_SS};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   digits;
  logic [15:0]   dec_digits;
  logic          tick;

  // One-second BCD decrement with cascaded borrows; never called on 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick       = (presc == LAST);
  assign dec_digits = bcd_dec(digits);
  assign {min_tens, min_ones, sec_tens, sec_ones} = digits;

`ifdef GAME_TIMER_BLINK_EN
  logic blank_q;
  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= START;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
`ifdef GAME_TIMER_BLINK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      expired <= 1'b0;
      if (load) begin
        state   <= IDLE;
        digits  <= START;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
`ifdef GAME_TIMER_BLINK_EN
        blank_q <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              presc <= '0;
              if (digits == 16'h0000) begin
                state   <= DONE;
                done    <= 1'b1;
                expired <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          // A pause request still lets this cycle's count and tick complete.
          RUN: begin
            if (tick) begin
              presc  <= '0;
              digits <= dec_digits;
            end else begin
              presc <= presc + 1'b1;
            end
            if (tick && dec_digits == 16'h0000) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
              expired <= 1'b1;
            end else if (pause && !start) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start || pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
`ifdef GAME_TIMER_BLINK_EN
            if (tick) begin
              presc   <= '0;
              blank_q <= ~blank_q;
            end else begin
              presc <= presc + 1'b1;
            end
`endif
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/game_timer_bcd.md
GAME_TIMER_BCD -- requirements
Module: game_timer_bcd

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1, meaning the countdown step rate in Hz; DIV = CLK_HZ/TICK_HZ, and DIV >= 2.
REQ-003 The block SHALL have parameter START_MM, default 8'h01, meaning the BCD minutes load value (tens in [7:4], ones in [3:0]).
REQ-004 The block SHALL have parameter START_SS, default 8'h30, meaning the BCD seconds load value; seconds tens <= 5.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load  input  1  single-cycle pulse; reload START_MM:START_SS and go to IDLE.
REQ-008 start  input  1  single-cycle pulse; begin or resume the countdown.
REQ-009 pause  input  1  single-cycle pulse; toggle between RUN and PAUSE.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD digits, each 0-9, driving per-digit bcdto7seg decoders.
REQ-011 running  output  1  high in the RUN state.
REQ-012 done  output  1  high in the DONE state.
REQ-013 expired  output  1  one-cycle pulse on entry to DONE.
REQ-014 blank  output  1  display blank request to the digit scan stage.

Function
REQ-015 The block SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-016 The block SHALL decode commands with priority load > start > pause when they coincide in one cycle; the lower-priority commands are dropped.
REQ-017 load in any state SHALL set the digits to START_MM:START_SS, clear the prescaler and enter IDLE on the next cycle.
REQ-018 start in IDLE SHALL clear the prescaler and enter RUN; if the digits are 00:00 it SHALL instead enter DONE and pulse expired.
REQ-019 start in PAUSE SHALL enter RUN with the prescaler value retained; start in RUN or DONE SHALL be ignored.
REQ-020 pause in RUN SHALL enter PAUSE; pause in PAUSE SHALL enter RUN; pause in IDLE or DONE SHALL be ignored.
REQ-021 The prescaler SHALL count 0..DIV-1 only in RUN and generate an internal tick on the cycle where it equals DIV-1, then wrap to 0.
REQ-022 On a tick the digits SHALL decrement by one second on the next clock edge, so the first decrement occurs DIV cycles after start is accepted.
REQ-023 The decrement SHALL use BCD borrow: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones; min_ones 0->9 borrows from min_tens.
REQ-024 No binary values above 9 (or above 5 for sec_tens) SHALL appear on the digit outputs.
REQ-025 When a decrement produces 00:00 the block SHALL enter DONE in the same edge and assert expired for exactly that one cycle.
REQ-026 In DONE the digits SHALL hold 00:00 and done SHALL stay high until load or reset.
REQ-027 In PAUSE the digits and the prescaler SHALL hold.
REQ-028 All outputs SHALL be registered and SHALL NOT depend combinationally on the inputs.

Reset
REQ-029 reset SHALL override all commands.
REQ-030 On reset the state SHALL be IDLE, the digits START_MM:START_SS, the prescaler 0, and running, done, expired and blank all 0.
REQ-031 reset asserted mid-RUN SHALL discard any pending tick; no expired pulse SHALL be emitted.

Configuration
REQ-032 The blink feature SHALL be controlled by macro GAME_TIMER_BLINK_EN.
REQ-033 With GAME_TIMER_BLINK_EN defined, blank SHALL toggle on every prescaler wrap while in DONE; the prescaler also runs in DONE, and blank is forced to 0 on leaving DONE.
REQ-034 Without GAME_TIMER_BLINK_EN, blank SHALL be constant 0 and no blink logic SHALL be synthesised.

Verification (CLK_HZ=4, TICK_HZ=1, DIV=4)
REQ-035 reset, start at cycle 0 -> digits 01:30 through cycle 3, then 01:29 after cycle 4; running=1.
REQ-036 Load START 00:10 and run across a tick -> digits go 00:10 -> 00:09; with START 01:00, one tick -> 00:59; with START 10:00, one tick -> 09:59.
REQ-037 Load START 00:01, start, run 4 cycles -> digits 00:00, done=1, expired high exactly 1 cycle, running=0; further start has no effect.
REQ-038 pause issued 2 cycles after a tick, hold 10 cycles, then start -> next decrement occurs 2 cycles after resume.
REQ-039 load, start and pause asserted in the same cycle while in RUN -> IDLE with START values; asserting reset mid-RUN -> reset values, no expired pulse.
REQ-040 With GAME_TIMER_BLINK_EN defined, in DONE -> blank toggles every 4 cycles; after load, blank=0.
